// File: rtl/burst_slot_scheduler_pkg.sv
// Shared types and constants for the burst slot scheduler: FSM state encoding,
// one-hot grant codes and a constant-width helper.
package heai_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SLOT,
        S_PA_LEAD,
        S_ON_AIR,
        S_PA_TAIL
    } state_e;

    localparam logic [1:0] GRANT_NONE   = 2'b00;
    localparam logic [1:0] GRANT_BEACON = 2'b01;
    localparam logic [1:0] GRANT_DATA   = 2'b10;

    // Bits needed to hold values 0..n-1 (never less than 1).
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/burst_slot_scheduler_slot_timer.sv
// Free-running slot counter: registered slot_start pulse while the counter is 0,
// plus combinational end-of-slot and PA lead-point strobes for the scheduler FSM.
module slot_timer
    import heai_sched_pkg::*;
#(
    parameter int SLOT_LEN = 4096,
    parameter int PA_LEAD  = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic slot_start_o,
    output logic slot_end_o,
    output logic lead_point_o
);

    localparam int            CW      = clog2(SLOT_LEN);
    localparam logic [CW-1:0] LAST    = CW'(SLOT_LEN - 1);
    localparam logic [CW-1:0] LEAD_AT = CW'(SLOT_LEN - PA_LEAD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          slot_start_q, slot_start_d;

    assign slot_end_o   = (cnt_q == LAST);
    assign lead_point_o = (cnt_q == LEAD_AT);
    assign cnt_d        = slot_end_o ? '0 : cnt_q + 1'b1;
    // Registered one cycle early so the pulse lines up with counter == 0.
    assign slot_start_d = slot_end_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            slot_start_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            slot_start_q <= slot_start_d;
        end
    end

    assign slot_start_o = slot_start_q;

endmodule

// File: rtl/burst_slot_scheduler.sv
// Arbitrates beacon/data burst requests, aligns each burst to a slot boundary and
// sequences PA enable around it. Define BURST_STATS_EN to add burst/timeout counters.
module burst_slot_scheduler
    import heai_sched_pkg::*;
#(
    parameter int SLOT_LEN      = 4096,
    parameter int PA_LEAD       = 64,
    parameter int PA_TAIL       = 32,
    parameter int BURST_TIMEOUT = 2048
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_beacon,
    input  logic       req_data,
    input  logic       is_armed,
    input  logic       iq_valid,
    input  logic       err_clear,
    output logic [1:0] grant,
    output logic       fire_burst,
    output logic       pa_enable,
    output logic       slot_start,
    output logic       done,
    output logic       aborted,
    output logic       timeout_err
`ifdef BURST_STATS_EN
    ,
    output logic [15:0] burst_count,
    output logic [7:0]  timeout_count
`endif
);

    localparam int            TOW    = clog2(BURST_TIMEOUT);
    localparam int            TLW    = clog2(PA_TAIL);
    localparam logic [TOW-1:0] TO_LAST = TOW'(BURST_TIMEOUT - 1);
    localparam logic [TLW-1:0] TL_LAST = TLW'(PA_TAIL - 1);

    logic slot_end, lead_point;

    slot_timer #(
        .SLOT_LEN (SLOT_LEN),
        .PA_LEAD  (PA_LEAD)
    ) u_slot_timer (
        .clk_i        (clock),
        .rst_ni       (reset_n),
        .slot_start_o (slot_start),
        .slot_end_o   (slot_end),
        .lead_point_o (lead_point)
    );

    state_e         state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic           fire_q, fire_d;
    logic           pa_q, pa_d;
    logic           done_q, done_d;
    logic           abort_q, abort_d;
    logic           err_q, err_d;
    logic           rr_q, rr_d;
    logic           seen_q, seen_d;
    logic [TOW-1:0] to_q, to_d;
    logic [TLW-1:0] tl_q, tl_d;
    logic           to_hit;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        fire_d  = 1'b0;
        pa_d    = pa_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        rr_d    = rr_q;
        seen_d  = seen_q;
        to_d    = to_q;
        tl_d    = tl_q;
        to_hit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // rr_q set means data goes first when both are requesting.
                if ((req_beacon || req_data) && is_armed) begin
                    if (req_beacon && (!req_data || !rr_q)) grant_d = GRANT_BEACON;
                    else                                    grant_d = GRANT_DATA;
                    state_d = S_WAIT_SLOT;
                end
            end
            S_WAIT_SLOT: begin
                if (lead_point) begin
                    pa_d    = 1'b1;
                    state_d = S_PA_LEAD;
                end
            end
            S_PA_LEAD: begin
                if (!is_armed) begin
                    abort_d = 1'b1;
                    grant_d = GRANT_NONE;
                    pa_d    = 1'b0;
                    state_d = S_IDLE;
                end else if (slot_end) begin
                    fire_d  = 1'b1;
                    to_d    = '0;
                    seen_d  = 1'b0;
                    state_d = S_ON_AIR;
                end
            end
            S_ON_AIR: begin
                to_d = to_q + 1'b1;
                if (iq_valid) seen_d = 1'b1;
                if (seen_q && !iq_valid) begin
                    tl_d    = '0;
                    state_d = S_PA_TAIL;
                end else if (to_q == TO_LAST) begin
                    to_hit  = 1'b1;
                    tl_d    = '0;
                    state_d = S_PA_TAIL;
                end
            end
            S_PA_TAIL: begin
                tl_d = tl_q + 1'b1;
                if (tl_q == TL_LAST) begin
                    pa_d    = 1'b0;
                    done_d  = 1'b1;
                    grant_d = GRANT_NONE;
                    rr_d    = grant_q[0];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh timeout wins over a simultaneous clear.
        err_d = to_hit | (err_q & ~err_clear);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= GRANT_NONE;
            fire_q  <= 1'b0;
            pa_q    <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            rr_q    <= 1'b0;
            seen_q  <= 1'b0;
            to_q    <= '0;
            tl_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            fire_q  <= fire_d;
            pa_q    <= pa_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            rr_q    <= rr_d;
            seen_q  <= seen_d;
            to_q    <= to_d;
            tl_q    <= tl_d;
        end
    end

    assign grant       = grant_q;
    assign fire_burst  = fire_q;
    assign pa_enable   = pa_q;
    assign done        = done_q;
    assign aborted     = abort_q;
    assign timeout_err = err_q;

`ifdef BURST_STATS_EN
    logic [15:0] bcnt_q, bcnt_d;
    logic [7:0]  tcnt_q, tcnt_d;

    assign bcnt_d = (done_d && (bcnt_q != '1)) ? bcnt_q + 1'b1 : bcnt_q;
    assign tcnt_d = (to_hit && (tcnt_q != '1)) ? tcnt_q + 1'b1 : tcnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bcnt_q <= '0;
            tcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign burst_count   = bcnt_q;
    assign timeout_count = tcnt_q;
`endif

endmodule

// File: tb/tb_burst_slot_scheduler.sv
// Bench for burst_slot_scheduler with SLOT_LEN=64, PA_LEAD=8, PA_TAIL=4, BURST_TIMEOUT=40.
// Expected output values are queued per absolute cycle and compared on the falling edge.
module tb_burst_slot_scheduler;

    localparam int SLOT_LEN      = 64;
    localparam int PA_LEAD       = 8;
    localparam int PA_TAIL       = 4;
    localparam int BURST_TIMEOUT = 40;
    localparam int LEAD_AT       = SLOT_LEN - PA_LEAD - 1;

    localparam int SIG_GRANT = 0;
    localparam int SIG_FIRE  = 1;
    localparam int SIG_PA    = 2;
    localparam int SIG_DONE  = 3;
    localparam int SIG_ABORT = 4;
    localparam int SIG_ERR   = 5;
    localparam int SIG_SS    = 6;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_beacon = 1'b0;
    logic       req_data = 1'b0;
    logic       is_armed = 1'b1;
    logic       iq_valid = 1'b0;
    logic       err_clear = 1'b0;
    logic [1:0] grant;
    logic       fire_burst, pa_enable, slot_start, done, aborted, timeout_err;
`ifdef BURST_STATS_EN
    logic [15:0] burst_count;
    logic [7:0]  timeout_count;
`endif

    burst_slot_scheduler #(
        .SLOT_LEN      (SLOT_LEN),
        .PA_LEAD       (PA_LEAD),
        .PA_TAIL       (PA_TAIL),
        .BURST_TIMEOUT (BURST_TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_beacon    (req_beacon),
        .req_data      (req_data),
        .is_armed      (is_armed),
        .iq_valid      (iq_valid),
        .err_clear     (err_clear),
        .grant         (grant),
        .fire_burst    (fire_burst),
        .pa_enable     (pa_enable),
        .slot_start    (slot_start),
        .done          (done),
        .aborted       (aborted),
        .timeout_err   (timeout_err)
`ifdef BURST_STATS_EN
        ,
        .burst_count   (burst_count),
        .timeout_count (timeout_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        int         sig;
        logic [1:0] val;
        string      name;
    } exp_t;

    typedef struct {
        string      name;
        logic       b;
        logic       d;
        int         req_cnt;
        int         iq_d;
        int         iq_len;
        int         abort_k;
        logic       clr_same;
        logic [1:0] exp_grant;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[4];
    int   cyc = 0;
    int   spos = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_fire = 0;
    int   n_done = 0;
    int   n_abort = 0;
    int   exp_done = 0;
    int   exp_abort = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference slot position: same free-running wrap as the slot counter.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) spos <= 0;
        else          spos <= (spos == SLOT_LEN - 1) ? 0 : spos + 1;
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", nm, cyc, act, expv);
        end
    endtask

    function automatic logic [15:0] sample(input int s);
        case (s)
            SIG_GRANT: return {14'd0, grant};
            SIG_FIRE:  return {15'd0, fire_burst};
            SIG_PA:    return {15'd0, pa_enable};
            SIG_DONE:  return {15'd0, done};
            SIG_ABORT: return {15'd0, aborted};
            SIG_ERR:   return {15'd0, timeout_err};
            SIG_SS:    return {15'd0, slot_start};
            default:   return 16'hxxxx;
        endcase
    endfunction

    task automatic push(input int c, input int s, input logic [1:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.sig = s; e.val = v; e.name = nm;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (fire_burst === 1'b1) n_fire++;
        if (done === 1'b1)       n_done++;
        if (aborted === 1'b1)    n_abort++;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                check(exp_q[i].name, sample(exp_q[i].sig), {14'd0, exp_q[i].val});
                exp_q.delete(i);
            end else if (exp_q[i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale %s: due cycle %0d never compared", exp_q[i].name, exp_q[i].cyc);
                exp_q.delete(i);
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic wait_spos(input int c);
        int n;
        n = 0;
        @(negedge clock);
        while (spos != c && n < 3 * SLOT_LEN) begin
            @(negedge clock);
            n++;
        end
        if (spos != c) check("wait_spos", 16'(spos), 16'(c));
    endtask

    task automatic run_burst(input vec_t v);
        int t0, L, F, E, Dn, Ab;
        wait_spos(v.req_cnt);
        t0 = cyc;
        req_beacon = v.b;
        req_data   = v.d;
        L  = t0 + (LEAD_AT + 1 - v.req_cnt) + ((v.req_cnt < LEAD_AT) ? 0 : SLOT_LEN);
        F  = L + PA_LEAD;
        push(t0 + 1, SIG_GRANT, v.exp_grant, {v.name, ".grant"});
        push(L - 1, SIG_PA, 2'd0, {v.name, ".pa_pre"});
        push(L,     SIG_PA, 2'd1, {v.name, ".pa_rise"});
        push(F - 1, SIG_FIRE, 2'd0, {v.name, ".fire_pre"});
        push(F - 1, SIG_SS, 2'd0, {v.name, ".ss_pre"});
        push(F,     SIG_SS, 2'd1, {v.name, ".ss"});
        if (v.req_cnt >= LEAD_AT) begin
            push(t0 + (SLOT_LEN - v.req_cnt), SIG_FIRE, 2'd0, {v.name, ".no_fire_now"});
            push(t0 + (SLOT_LEN - v.req_cnt), SIG_PA,   2'd0, {v.name, ".no_pa_now"});
        end
        if (v.abort_k >= 0) begin
            Ab = L + v.abort_k;
            push(Ab,     SIG_PA,    2'd1, {v.name, ".pa_hold"});
            push(Ab,     SIG_ABORT, 2'd0, {v.name, ".abort_pre"});
            push(Ab + 1, SIG_ABORT, 2'd1, {v.name, ".abort"});
            push(Ab + 1, SIG_PA,    2'd0, {v.name, ".abort_pa"});
            push(Ab + 1, SIG_GRANT, 2'd0, {v.name, ".abort_grant"});
            push(Ab + 2, SIG_ABORT, 2'd0, {v.name, ".abort_post"});
            push(F,      SIG_FIRE,  2'd0, {v.name, ".no_fire"});
            push(F,      SIG_PA,    2'd0, {v.name, ".no_pa"});
            wait_cyc(Ab);
            is_armed = 1'b0;
            wait_cyc(Ab + 1);
            is_armed   = 1'b1;
            req_beacon = 1'b0;
            req_data   = 1'b0;
            exp_abort++;
            wait_cyc(F + 2);
        end else begin
            push(F,     SIG_FIRE,  2'd1, {v.name, ".fire"});
            push(F,     SIG_GRANT, v.exp_grant, {v.name, ".grant_fire"});
            push(F,     SIG_PA,    2'd1, {v.name, ".pa_fire"});
            push(F + 1, SIG_FIRE,  2'd0, {v.name, ".fire_post"});
            if (v.iq_len > 0) begin
                E  = F + v.iq_d + v.iq_len;
                Dn = E + 1 + PA_TAIL;
                push(E, SIG_ERR, 2'd0, {v.name, ".no_err"});
            end else begin
                Dn = F + BURST_TIMEOUT + PA_TAIL;
                push(F + BURST_TIMEOUT - 1, SIG_ERR, 2'd0, {v.name, ".err_pre"});
                push(F + BURST_TIMEOUT,     SIG_ERR, 2'd1, {v.name, ".err"});
                if (v.clr_same) push(F + BURST_TIMEOUT + 1, SIG_ERR, 2'd1, {v.name, ".err_sticky"});
                push(Dn + 2, SIG_ERR, 2'd1, {v.name, ".err_before_clr"});
                push(Dn + 3, SIG_ERR, 2'd0, {v.name, ".err_cleared"});
            end
            push(Dn - 1, SIG_PA,    2'd1, {v.name, ".pa_tail"});
            push(Dn - 1, SIG_DONE,  2'd0, {v.name, ".done_pre"});
            push(Dn,     SIG_PA,    2'd0, {v.name, ".pa_fall"});
            push(Dn,     SIG_DONE,  2'd1, {v.name, ".done"});
            push(Dn,     SIG_GRANT, 2'd0, {v.name, ".grant_rel"});
            push(Dn + 1, SIG_DONE,  2'd0, {v.name, ".done_post"});
            if (v.iq_len > 0) begin
                wait_cyc(F + v.iq_d);
                iq_valid = 1'b1;
                wait_cyc(F + v.iq_d + v.iq_len);
                iq_valid = 1'b0;
            end else if (v.clr_same) begin
                wait_cyc(F + BURST_TIMEOUT - 1);
                err_clear = 1'b1;
                wait_cyc(F + BURST_TIMEOUT);
                err_clear = 1'b0;
            end
            wait_cyc(Dn);
            req_beacon = 1'b0;
            req_data   = 1'b0;
            if (v.iq_len == 0) begin
                wait_cyc(Dn + 2);
                err_clear = 1'b1;
                wait_cyc(Dn + 3);
                err_clear = 1'b0;
            end
            exp_done++;
            wait_cyc(Dn + 4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, F1, F2, D1, D2, fire0;

        vecs[0] = '{"basic",   1'b1, 1'b0, 10, 1, 20, -1, 1'b0, 2'b01};
        vecs[1] = '{"timeout", 1'b1, 1'b0, 20, 0,  0, -1, 1'b1, 2'b01};
        vecs[2] = '{"abort",   1'b0, 1'b1,  5, 0,  0,  3, 1'b0, 2'b10};
        vecs[3] = '{"late",    1'b0, 1'b1, 60, 2, 10, -1, 1'b0, 2'b10};

        repeat (3) @(negedge clock);
        check("rst.grant", {14'd0, grant}, 16'd0);
        check("rst.fire",  {15'd0, fire_burst}, 16'd0);
        check("rst.pa",    {15'd0, pa_enable}, 16'd0);
        check("rst.ss",    {15'd0, slot_start}, 16'd0);
        check("rst.done",  {15'd0, done}, 16'd0);
        check("rst.abort", {15'd0, aborted}, 16'd0);
        check("rst.err",   {15'd0, timeout_err}, 16'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) run_burst(vecs[i]);

        // Both requesters held: beacon wins slot N, data wins slot N+1.
        fire0 = n_fire;
        wait_spos(10);
        t0 = cyc;
        req_beacon = 1'b1;
        req_data   = 1'b1;
        F1 = t0 + (LEAD_AT + 1 - 10) + PA_LEAD;
        D1 = F1 + 1 + 20 + 1 + PA_TAIL;
        F2 = F1 + SLOT_LEN;
        D2 = F2 + 1 + 20 + 1 + PA_TAIL;
        push(t0 + 1, SIG_GRANT, 2'b01, "rr.grant1");
        push(F1,     SIG_FIRE,  2'd1,  "rr.fire1");
        push(F1,     SIG_GRANT, 2'b01, "rr.grant1_fire");
        push(D1,     SIG_DONE,  2'd1,  "rr.done1");
        push(D1,     SIG_GRANT, 2'b00, "rr.grant1_rel");
        push(D1 + 1, SIG_GRANT, 2'b10, "rr.grant2");
        push(F2 - PA_LEAD - 1, SIG_PA, 2'd0, "rr.pa2_pre");
        push(F2 - PA_LEAD,     SIG_PA, 2'd1, "rr.pa2_rise");
        push(F2 - 1, SIG_FIRE,  2'd0,  "rr.fire2_pre");
        push(F2,     SIG_FIRE,  2'd1,  "rr.fire2");
        push(F2,     SIG_GRANT, 2'b10, "rr.grant2_fire");
        push(D2,     SIG_DONE,  2'd1,  "rr.done2");
        push(D2,     SIG_GRANT, 2'b00, "rr.grant2_rel");
        wait_cyc(F1 + 1);  iq_valid = 1'b1;
        wait_cyc(F1 + 21); iq_valid = 1'b0;
        wait_cyc(F2 + 1);  iq_valid = 1'b1;
        wait_cyc(F2 + 21); iq_valid = 1'b0;
        wait_cyc(D2);
        req_beacon = 1'b0;
        req_data   = 1'b0;
        exp_done += 2;
        wait_cyc(D2 + 3);
        check("rr.fire_count", 16'(n_fire - fire0), 16'd2);

`ifdef BURST_STATS_EN
        check("stats.bursts",   burst_count, 16'(exp_done));
        check("stats.timeouts", {8'd0, timeout_count}, 16'd1);
`endif

        // Reset asserted while on air.
        wait_spos(10);
        t0 = cyc;
        req_beacon = 1'b1;
        F1 = t0 + (LEAD_AT + 1 - 10) + PA_LEAD;
        push(t0 + 1, SIG_GRANT, 2'b01, "rst_mid.grant");
        push(F1,     SIG_FIRE,  2'd1,  "rst_mid.fire");
        wait_cyc(F1 + 2);
        iq_valid = 1'b1;
        wait_cyc(F1 + 5);
        reset_n = 1'b0;
        #1;
        check("rst_mid.pa",    {15'd0, pa_enable}, 16'd0);
        check("rst_mid.grant", {14'd0, grant}, 16'd0);
        check("rst_mid.fire",  {15'd0, fire_burst}, 16'd0);
`ifdef BURST_STATS_EN
        check("rst_mid.bursts",   burst_count, 16'd0);
        check("rst_mid.timeouts", {8'd0, timeout_count}, 16'd0);
`endif
        iq_valid   = 1'b0;
        req_beacon = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_mid.idle_grant", {14'd0, grant}, 16'd0);

        run_burst(vecs[0]);

        repeat (4) @(negedge clock);
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        check("done_count",    16'(n_done), 16'(exp_done));
        check("abort_count",   16'(n_abort), 16'(exp_abort));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
